ysyx_22041071_mem_arb: RTL
==========================

// Module: ysyx_22041071_mem_arb
// PURPOSE
//   Shares the single core memory port between instruction fetch (IF) and data access (MEM stage).
//   One transaction is outstanding at a time: grant, issue on the bus, wait for the response, route it back.
//   MEM has priority; a streak counter guarantees IF forward progress.
//   A fetch flush (branch/jalr redirect) squashes an in-flight IF response. A watchdog timeout prevents pipeline deadlock.
// PARAMETERS
//   MAX_MEM_STREAK  4    consecutive MEM grants allowed while IF is waiting; the next grant goes to IF
//   TIMEOUT         255  cycles in WAIT with no bus response before an error completion is forced
// PORTS
//   clk            in   1   core clock
//   reset          in   1   synchronous, active-high reset
//   if_req_valid   in   1   IF read request
//   if_req_ready   out  1   IF request accepted this cycle
//   if_addr        in   64  IF fetch address
//   if_flush       in   1   redirect; squash any IF transaction in flight
//   if_rsp_valid   out  1   IF response pulse
//   if_rsp_data    out  32  instruction: bus_rsp_rdata[63:32] if latched addr[2]=1, else [31:0]
//   mem_req_valid  in   1   MEM request
//   mem_req_ready  out  1   MEM request accepted this cycle
//   mem_addr       in   64  data address
//   mem_wen        in   1   1 = store, 0 = load
//   mem_wdata      in   64  store data
//   mem_wmask      in   8   store byte strobes
//   mem_rsp_valid  out  1   MEM response pulse (load data or store ack)
//   mem_rsp_rdata  out  64  load data
//   bus_req_valid  out  1   downstream request valid
//   bus_req_ready  in   1   downstream accepts the request
//   bus_addr       out  64  latched address
//   bus_wen        out  1   latched write enable; always 0 for IF
//   bus_wdata      out  64  latched store data
//   bus_wmask      out  8   latched strobes; always 0 for IF
//   bus_rsp_valid  in   1   downstream response
//   bus_rsp_rdata  in   64  downstream read data
//   bus_rsp_err    in   1   downstream error, qualified by bus_rsp_valid
//   busy           out  1   state != IDLE
//   err            out  1   one-cycle pulse on bus error or timeout
// BEHAVIOUR
//   Reset: state=IDLE; owner, streak, timer=0; all bus_* latches=0.
//   Reset: every output is 0 (busy=0, *_ready=0, *_rsp_valid=0, err=0).
//   Reset mid-transaction abandons it; a late bus_rsp_valid seen in IDLE is ignored.
//   FSM:
//     IDLE -> ISSUE on grant.
//     ISSUE -> WAIT on bus_req_valid & bus_req_ready.
//     WAIT -> IDLE on bus_rsp_valid or timeout.
//   IDLE grant (combinational ready, IDLE only):
//     Only MEM valid -> MEM. Only IF valid -> IF.
//     Both valid -> MEM, unless streak==MAX_MEM_STREAK, then IF.
//     At most one of if_req_ready / mem_req_ready is high in any cycle.
//     On the grant edge, latch owner, addr, wen, wdata, wmask.
//   Streak: +1 on a MEM grant while if_req_valid=1 (saturates).
//   Streak: cleared on an IF grant, or on a MEM grant with if_req_valid=0.
//   ISSUE: bus_req_valid=1 with stable latched fields until bus_req_ready.
//   WAIT: timer counts from 0.
//   WAIT: on bus_rsp_valid, the owner's rsp_valid=1 combinationally that cycle and data passes through.
//   WAIT: err=bus_rsp_err in that same cycle.
//   WAIT: if timer==TIMEOUT without a response, the owner's rsp_valid=1 with data 0, err=1, then -> IDLE.
//   Minimum latency: grant at edge N, bus_req_valid in cycle N+1, rsp in cycle N+2 if the bus is zero-wait.
//   Flush: if_flush=1 while owner=IF and state!=IDLE sets a squash flag.
//   Flush: with the squash flag set (or if_flush in the same cycle), if_rsp_valid is suppressed.
//   Flush: the bus transaction still completes; the flag clears on return to IDLE.
//   Flush: no effect in IDLE or when owner=MEM.
//   Flush: in IDLE, if_flush masks if_req_valid for that cycle.
//   Back-to-back: the next grant is possible in the cycle after WAIT->IDLE. No request is granted in the completion cycle.
// TESTING
//   Reset: hold reset 3 cycles with both valids=1 -> all outputs 0, busy=0. Release -> MEM granted first.
//   Zero-wait load: mem addr=0x80000010, rdata=0x1122334455667788 -> mem_rsp_valid 2 cycles after grant with that data; if_rsp_valid=0.
//   IF half select: if_addr=0x80000004, rdata=0xAAAA_BBBB_CCCC_DDDD -> if_rsp_data=0xAAAABBBB.
//   Streak: IF and MEM continuously valid -> grant order MEM x4, IF, MEM x4, IF.
//   Flush: if_flush pulsed in WAIT with a 5-cycle bus delay -> bus completes, if_rsp_valid never asserts, busy drops.
//   Timeout: bus never responds -> owner rsp_valid with data 0 and err=1 exactly TIMEOUT cycles into WAIT; state IDLE next cycle.

Source files
------------

// File: rtl/ysyx_22041071_mem_arb.sv
// Arbiter sharing one memory port between instruction fetch and the MEM stage.
// One transaction in flight: grant in IDLE, drive the bus in ISSUE, route the response in WAIT.
module ysyx_22041071_mem_arb #(
  parameter int MAX_MEM_STREAK = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  output logic        mem_rsp_valid,
  output logic [63:0] mem_rsp_rdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic        bus_wen,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rsp_rdata,
  input  logic        bus_rsp_err,
  output logic        busy,
  output logic        err
);

  localparam int SW = $clog2(MAX_MEM_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q;
  logic [SW-1:0] streak_q;
  logic [TW-1:0] timer_q;
  logic          squash_q;
  logic [63:0]   addr_q;
  logic          wen_q;
  logic [63:0]   wdata_q;
  logic [7:0]    wmask_q;

  logic          idle_s;
  logic          if_cand_s;
  logic          grant_mem_s;
  logic          grant_if_s;
  logic          done_s;
  logic          timeout_s;
  logic [63:0]   rsp_data_s;

  function automatic logic [31:0] pick_half(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

  // A redirect in the same cycle withdraws the fetch request from arbitration.
  assign idle_s      = (state_q == ST_IDLE) & ~reset;
  assign if_cand_s   = if_req_valid & ~if_flush;
  assign grant_mem_s = idle_s & mem_req_valid & (~if_cand_s | (streak_q != STREAK_MAX));
  assign grant_if_s  = idle_s & if_cand_s & ~grant_mem_s;
  assign timeout_s   = (state_q == ST_WAIT) & ~bus_rsp_valid & (timer_q == TIMER_MAX);
  assign done_s      = (state_q == ST_WAIT) & (bus_rsp_valid | timeout_s);
  assign rsp_data_s  = bus_rsp_valid ? bus_rsp_rdata : 64'd0;

  assign bus_addr  = addr_q;
  assign bus_wen   = wen_q;
  assign bus_wdata = wdata_q;
  assign bus_wmask = wmask_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_mem_s | grant_if_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus_req_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    if_req_ready  = 1'b0;
    mem_req_ready = 1'b0;
    bus_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    if_rsp_data   = 32'd0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 64'd0;
    busy          = 1'b0;
    err           = 1'b0;
    if (!reset) begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if_req_ready  = grant_if_s;
          mem_req_ready = grant_mem_s;
        end
        ST_ISSUE: begin
          bus_req_valid = 1'b1;
        end
        ST_WAIT: begin
          if (done_s) begin
            err = bus_rsp_valid ? bus_rsp_err : 1'b1;
            if (owner_q == OWN_MEM) begin
              mem_rsp_valid = 1'b1;
              mem_rsp_rdata = rsp_data_s;
            end else begin
              if_rsp_valid = ~squash_q & ~if_flush;
              if_rsp_data  = pick_half(rsp_data_s, addr_q[2]);
            end
          end else begin
            err = 1'b0;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end else begin
      busy = 1'b0;
    end
  end

  // Grant-time latch of the request and MEM streak bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OWN_IF;
      streak_q <= '0;
      addr_q   <= 64'd0;
      wen_q    <= 1'b0;
      wdata_q  <= 64'd0;
      wmask_q  <= 8'd0;
    end else if (grant_mem_s) begin
      owner_q <= OWN_MEM;
      addr_q  <= mem_addr;
      wen_q   <= mem_wen;
      wdata_q <= mem_wdata;
      wmask_q <= mem_wmask;
      if (!if_cand_s) begin
        streak_q <= '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_q <= streak_q + SW'(1);
      end else begin
        streak_q <= streak_q;
      end
    end else if (grant_if_s) begin
      owner_q  <= OWN_IF;
      addr_q   <= if_addr;
      wen_q    <= 1'b0;
      wdata_q  <= 64'd0;
      wmask_q  <= 8'd0;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_q;
      addr_q   <= addr_q;
      wen_q    <= wen_q;
      wdata_q  <= wdata_q;
      wmask_q  <= wmask_q;
      streak_q <= streak_q;
    end
  end

  // Watchdog: counts WAIT cycles without a response, restarts from zero on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if ((state_q != ST_WAIT) || done_s) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // Squash flag: a redirect during a fetch drops its response, the bus beat still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      squash_q <= 1'b0;
    end else if ((state_q == ST_IDLE) || done_s) begin
      squash_q <= 1'b0;
    end else if (if_flush && (owner_q == OWN_IF)) begin
      squash_q <= 1'b1;
    end else begin
      squash_q <= squash_q;
    end
  end

endmodule
